// File: rtl/dram_port_arbiter_if.sv
// Bundle of the CPU load/store, Arduino read and RAM port signals that pass
// through the DRAM port arbiter. The slave side is the arbiter; the master
// side is whatever surrounds it (requesters plus the RAM macro).
interface dram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int LANES  = 16,
    parameter int ARD_W  = 16
);
    logic                    cpu_req;
    logic                    cpu_we;
    logic                    cpu_vec;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [LANES*DATA_W-1:0] cpu_wdata;
    logic [LANES*DATA_W-1:0] cpu_rdata;
    logic                    cpu_done;

    logic                    ard_req;
    logic [ADDR_W-1:0]       ard_addr;
    logic [ARD_W-1:0]        ard_rdata;
    logic                    ard_valid;

    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_vec, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  ard_req, ard_addr,
        output ard_rdata, ard_valid,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_vec, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output ard_req, ard_addr,
        input  ard_rdata, ard_valid,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Shares one single-port data RAM between the CPU load/store path (scalar or
// LANES-wide vector) and the Arduino read path. Vector accesses are split into
// LANES consecutive word accesses; round-robin arbitration prevents starvation.
module dram_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int LANES  = 16,
    parameter int ARD_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    dram_port_arbiter_if.slave bus,
    output logic               busy
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_WAIT,
        ARD_RD,
        ARD_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nx;

    logic                    last_grant_ard;
    logic [LW-1:0]           lane;
    logic                    grant_cpu;
    logic                    grant_ard;
    logic                    cpu_fin;
    logic                    ard_fin;

    logic [ADDR_W-1:0]       addr_l;
    logic                    we_l;
    logic                    vec_l;
    logic [LANES*DATA_W-1:0] wdata_l;

    logic                    vld_p1;
    logic [LW-1:0]           lane_p1;

    logic [LANES*DATA_W-1:0] cpu_rdata_q;
    logic [ARD_W-1:0]        ard_rdata_q;
    logic                    cpu_done_q;
    logic                    ard_valid_q;

    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_wdata;

    // Index of the lane that ends the CPU access phase.
    function automatic logic [LW-1:0] final_lane(input logic vec);
        return vec ? LW'(LANES - 1) : '0;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Round-robin arbitration in IDLE and lane sequencing through the access.
    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_ard = 1'b0;
        cpu_fin   = 1'b0;
        ard_fin   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req && (!bus.ard_req || last_grant_ard)) begin
                    grant_cpu = 1'b1;
                    state_nx  = CPU_ACC;
                end else if (bus.ard_req) begin
                    grant_ard = 1'b1;
                    state_nx  = ARD_RD;
                end
            end
            CPU_ACC: begin
                if (lane == final_lane(vec_l)) begin
                    if (we_l) begin
                        cpu_fin  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = CPU_WAIT;
                    end
                end
            end
            CPU_WAIT: begin
                cpu_fin  = 1'b1;
                state_nx = IDLE;
            end
            ARD_RD: begin
                state_nx = ARD_WAIT;
            end
            ARD_WAIT: begin
                ard_fin  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control: last grant, lane counter, read-capture pipeline and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_ard <= 1'b1;
            lane           <= '0;
            vld_p1         <= 1'b0;
            lane_p1        <= '0;
            cpu_done_q     <= 1'b0;
            ard_valid_q    <= 1'b0;
        end else begin
            cpu_done_q  <= cpu_fin;
            ard_valid_q <= ard_fin;
            // ---- p0 -> p1: read address issued, data returns next cycle ----
            vld_p1      <= (state == CPU_ACC) && !we_l;
            lane_p1     <= lane;
            if (grant_cpu) begin
                last_grant_ard <= 1'b0;
                lane           <= '0;
            end else if (grant_ard) begin
                last_grant_ard <= 1'b1;
                lane           <= '0;
            end else if (state == CPU_ACC) begin
                lane <= lane + LW'(1);
            end
        end
    end

    // Latch the winning request; later input changes do not disturb the access.
    always_ff @(posedge clk) begin
        if (grant_cpu) begin
            addr_l  <= bus.cpu_addr;
            we_l    <= bus.cpu_we;
            vec_l   <= bus.cpu_vec;
            wdata_l <= bus.cpu_wdata;
        end else if (grant_ard) begin
            addr_l  <= bus.ard_addr;
            we_l    <= 1'b0;
            vec_l   <= 1'b0;
        end
    end

    // Gather returning load words into their lanes and capture Arduino data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            ard_rdata_q <= '0;
        end else begin
            // ---- p1: RAM data for lane_p1 is valid now ----
            if (vld_p1) cpu_rdata_q[lane_p1*DATA_W +: DATA_W] <= bus.mem_rdata;
            if (state == ARD_WAIT) ard_rdata_q <= bus.mem_rdata[ARD_W-1:0];
        end
    end

    // RAM port drive; write enable only while stepping through a store.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            CPU_ACC: begin
                mem_addr  = addr_l + ADDR_W'(lane);
                mem_we    = we_l;
                mem_wdata = wdata_l[lane*DATA_W +: DATA_W];
            end
            ARD_RD: begin
                mem_addr  = addr_l;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.ard_rdata = ard_rdata_q;
    assign bus.ard_valid = ard_valid_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: a RAM macro model on the memory port, directed
// scenarios followed by random request pairs, all predicted by a
// transaction-level reference (latency table, grant order, word memory).
module tb_dram_port_arbiter;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int LANES  = 16;
    localparam int ARD_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    dram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .ARD_W(ARD_W)) bus ();

    dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .ARD_W(ARD_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // RAM macro: registered read (read-before-write), write on mem_we.
    logic [DATA_W-1:0] ram [logic [ADDR_W-1:0]];
    always @(posedge clk) begin
        bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : '0;
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end

    // Reference state.
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_rdata [LANES];
    logic [ARD_W-1:0]  exp_ard;
    bit                last_cpu;
    logic [ADDR_W-1:0] wq_a [$];
    logic [DATA_W-1:0] wq_d [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic int cpu_lat(input bit we, input bit vec);
        return we ? (vec ? LANES + 1 : 2) : (vec ? LANES + 2 : 3);
    endfunction

    function automatic logic [LANES*DATA_W-1:0] rand_wide();
        logic [LANES*DATA_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 20'hFFFF0 + ADDR_W'($urandom_range(0, 15));
        return 20'h00300 + ADDR_W'($urandom_range(0, 63));
    endfunction

    // Effect of one CPU transaction on the word memory / gathered load data.
    task automatic model_cpu(input bit we, input bit vec, input logic [ADDR_W-1:0] a,
                             input logic [LANES*DATA_W-1:0] wd);
        int n;
        n = vec ? LANES : 1;
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] la;
            la = a + ADDR_W'(i);
            if (we) begin
                ref_mem[la] = wd[i*DATA_W +: DATA_W];
                wq_a.push_back(la);
                wq_d.push_back(wd[i*DATA_W +: DATA_W]);
            end else begin
                exp_rdata[i] = ref_rd(la);
            end
        end
    endtask

    task automatic model_ard(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = ref_rd(a);
        exp_ard = w[ARD_W-1:0];
    endtask

    task automatic check_outputs();
        for (int i = 0; i < LANES; i++)
            check($sformatf("cpu_rdata[%0d]", i), bus.cpu_rdata[i*DATA_W +: DATA_W], exp_rdata[i]);
        check("ard_rdata", bus.ard_rdata, exp_ard);
    endtask

    // One CPU and/or Arduino request raised together, each dropped on its pulse.
    task automatic run_pair(input bit do_cpu, input bit do_ard, input bit c_we, input bit c_vec,
                            input logic [ADDR_W-1:0] c_addr, input logic [LANES*DATA_W-1:0] c_wd,
                            input logic [ADDR_W-1:0] a_addr);
        int lat_c, exp_c, exp_a, got_c, got_a, cyc, wi, c_start, a_start;
        bit cpu_first;
        wq_a.delete();
        wq_d.delete();
        lat_c     = cpu_lat(c_we, c_vec);
        cpu_first = do_cpu && (!do_ard || !last_cpu);
        c_start   = cpu_first ? 0 : 3;
        a_start   = (cpu_first && do_cpu) ? lat_c : 0;
        exp_c     = c_start + lat_c;
        exp_a     = a_start + 3;
        if (do_cpu && cpu_first) model_cpu(c_we, c_vec, c_addr, c_wd);
        if (do_ard) model_ard(a_addr);
        if (do_cpu && !cpu_first) model_cpu(c_we, c_vec, c_addr, c_wd);
        if (do_cpu && do_ard) last_cpu = !cpu_first;
        else                  last_cpu = do_cpu;

        bus.cpu_req   = do_cpu;
        bus.cpu_we    = c_we;
        bus.cpu_vec   = c_vec;
        bus.cpu_addr  = c_addr;
        bus.cpu_wdata = c_wd;
        bus.ard_req   = do_ard;
        bus.ard_addr  = a_addr;
        cyc = 0; wi = 0; got_c = -1; got_a = -1;
        while (((do_cpu && got_c < 0) || (do_ard && got_a < 0)) && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_we) begin
                if (wi < wq_a.size()) begin
                    check("wr_addr", bus.mem_addr, wq_a[wi]);
                    check("wr_data", bus.mem_wdata, wq_d[wi]);
                    check("wr_cycle", cyc, c_start + 1 + wi);
                end
                wi++;
            end
            if (bus.cpu_done) begin
                if (got_c < 0) got_c = cyc;
                bus.cpu_req = 1'b0;
            end
            if (bus.ard_valid) begin
                if (got_a < 0) got_a = cyc;
                bus.ard_req = 1'b0;
            end
            if (do_cpu && got_c < 0 && cyc > c_start) begin
                bus.cpu_addr  = ADDR_W'($urandom);
                bus.cpu_wdata = rand_wide();
                bus.cpu_we    = 1'($urandom);
                bus.cpu_vec   = 1'($urandom);
            end
            if (do_ard && got_a < 0 && cyc > a_start) bus.ard_addr = ADDR_W'($urandom);
        end
        bus.cpu_req = 1'b0;
        bus.ard_req = 1'b0;
        if (do_cpu) check("cpu_done_cycle", got_c, exp_c);
        if (do_ard) check("ard_valid_cycle", got_a, exp_a);
        check("write_count", wi, wq_a.size());
        check_outputs();
        @(posedge clk); #1;
        check("idle_after", {busy, bus.cpu_done, bus.ard_valid}, 3'b000);
    endtask

    // CPU vector load and Arduino read both held across three grants.
    task automatic run_alternate(input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] aa);
        bit who [3];
        int exp_t [3];
        int t, cyc, np, nw;
        bit first_cpu;
        first_cpu = !last_cpu;
        t = 0;
        for (int i = 0; i < 3; i++) begin
            who[i]   = (i % 2 == 0) ? first_cpu : !first_cpu;
            t       += who[i] ? cpu_lat(1'b0, 1'b1) : 3;
            exp_t[i] = t;
        end
        model_cpu(1'b0, 1'b1, ca, '0);
        model_ard(aa);
        last_cpu = who[2];

        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_vec  = 1'b1;
        bus.cpu_addr = ca;
        bus.ard_req  = 1'b1;
        bus.ard_addr = aa;
        cyc = 0; np = 0; nw = 0;
        while (np < 3 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_we) nw++;
            if (bus.cpu_done || bus.ard_valid) begin
                check($sformatf("alt_who%0d", np), bus.cpu_done, who[np]);
                check($sformatf("alt_cycle%0d", np), cyc, exp_t[np]);
                np++;
                if (np == 3) begin
                    bus.cpu_req = 1'b0;
                    bus.ard_req = 1'b0;
                end
            end
        end
        bus.cpu_req = 1'b0;
        bus.ard_req = 1'b0;
        check("alt_pulses", np, 3);
        check("alt_no_write", nw, 0);
        check_outputs();
        @(posedge clk); #1;
        check("alt_idle_after", {busy, bus.cpu_done, bus.ard_valid}, 3'b000);
    endtask

    // Vector store aborted by reset while lane 7 is on the RAM port.
    task automatic run_reset_mid(input logic [ADDR_W-1:0] a);
        logic [LANES*DATA_W-1:0] wd;
        int cyc, nd;
        wd = rand_wide();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_vec   = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        for (cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            check("rst_pre_we", bus.mem_we, 1'b1);
            check("rst_pre_addr", bus.mem_addr, a + ADDR_W'(cyc - 1));
        end
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_we", bus.mem_we, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cpu_done) nd++;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        check("rst_mid_no_done", nd, 0);
        for (int i = 0; i < 8; i++) ref_mem[a + ADDR_W'(i)] = wd[i*DATA_W +: DATA_W];
        for (int i = 0; i < LANES; i++) exp_rdata[i] = '0;
        exp_ard  = '0;
        last_cpu = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [LANES*DATA_W-1:0] wd;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_vec   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ard_req   = 1'b0;
        bus.ard_addr  = '0;
        for (int i = 0; i < LANES; i++) exp_rdata[i] = '0;
        exp_ard  = '0;
        last_cpu = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_cpu_done", bus.cpu_done, 1'b0);
        check("rst_ard_valid", bus.ard_valid, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_cpu_rdata_any", |bus.cpu_rdata, 1'b0);
        check("rst_ard_rdata", bus.ard_rdata, '0);
        rst = 1'b0;

        // Both from reset: CPU scalar store wins, Arduino then reads it back.
        wd = '0;
        wd[31:0] = 32'hDEADBEEF;
        run_pair(1'b1, 1'b1, 1'b1, 1'b0, 20'h00010, wd, 20'h00010);
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 20'h00010, '0, '0);

        // Vector store/load with lane i = 0x1000+i.
        for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = 32'h1000 + i;
        run_pair(1'b1, 1'b0, 1'b1, 1'b1, 20'h00100, wd, '0);
        run_pair(1'b1, 1'b0, 1'b0, 1'b1, 20'h00100, '0, '0);

        // Arduino read of 0x0000ABCD at word 5.
        wd = '0;
        wd[31:0] = 32'h0000ABCD;
        run_pair(1'b1, 1'b0, 1'b1, 1'b0, 20'h00005, wd, '0);
        run_pair(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 20'h00005);

        // Address wrap across the top of the address space.
        run_pair(1'b1, 1'b0, 1'b1, 1'b1, 20'hFFFF8, rand_wide(), '0);
        run_pair(1'b1, 1'b0, 1'b0, 1'b1, 20'hFFFF8, '0, '0);

        run_alternate(20'h00100, 20'h00005);

        run_reset_mid(20'h00200);
        run_pair(1'b1, 1'b0, 1'b0, 1'b1, 20'h00200, '0, '0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_pair(kind != 1, kind != 0, 1'($urandom), 1'($urandom),
                     rand_addr(), rand_wide(), rand_addr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares one single-port data RAM between two requesters:
  - the CPU load/store path (scalar or 16-lane vector access);
  - the external Arduino read path.
- Splits each vector access into 16 consecutive word accesses and gathers or scatters the lane data.
- Uses round-robin arbitration so neither requester starves.
- Sits between the CPU/chipset address decode and the DRAM macro in the processor top level.

Parameters:
ADDR_W, 20, word address width of RAM and requesters
DATA_W, 32, RAM word / lane width
LANES, 16, lanes per vector access
ARD_W, 16, width of Arduino read data (low bits of RAM word)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request, level, held until cpu_done
cpu_we  in  1  1=store, 0=load (sampled at grant)
cpu_vec  in  1  1=vector (LANES words), 0=scalar (lane 0 only)
cpu_addr  in  ADDR_W  base word address
cpu_wdata  in  LANES*DATA_W  store data, lane i = bits [i*DATA_W +: DATA_W]
cpu_rdata  out  LANES*DATA_W  gathered load data
cpu_done  out  1  one-cycle completion pulse
ard_req  in  1  Arduino read request, level, held until ard_valid
ard_addr  in  ADDR_W  Arduino word address
ard_rdata  out  ARD_W  Arduino read data
ard_valid  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - FSM = IDLE; lane = 0; last_grant = ARD, so the CPU wins the first tie.
  - cpu_rdata = 0, cpu_done = 0, ard_rdata = 0, ard_valid = 0.
  - mem_addr = 0, mem_we = 0, mem_wdata = 0, busy = 0.
- FSM states: IDLE, CPU_ACC, CPU_WAIT, ARD_RD, ARD_WAIT.
- IDLE arbitration and latching:
  - Requests are sampled only in IDLE.
  - If only one requester asserts, it is granted.
  - If both assert, the one not equal to last_grant is granted.
  - At grant: latch addr, we, vec and wdata; set last_grant; lane = 0.
- CPU_ACC:
  - Drives mem_addr = base + lane (mod 2^ADDR_W; wrap at top of address space is legal).
  - Drives mem_we = latched we and mem_wdata = lane slice of latched wdata.
  - lane increments every cycle.
  - Last lane is LANES-1 for vector, 0 for scalar. After the last lane: store -> IDLE with cpu_done pulse; load -> CPU_WAIT.
- Load capture:
  - The word read for lane k is captured into cpu_rdata lane k on the cycle after its address (1-cycle RAM latency, pipelined lane index).
  - CPU_WAIT captures the final lane, pulses cpu_done and returns to IDLE.
  - cpu_rdata is complete when cpu_done=1.
  - Scalar load updates lane 0 only; other lanes hold previous values.
- Latency, with request sampled in cycle 0:
  - scalar store: mem write in cycle 1, done in cycle 2;
  - vector store: writes in cycles 1–16, done in cycle 17;
  - scalar load: done in cycle 3;
  - vector load: addresses in cycles 1–16, done in cycle 18.
- Arduino path:
  - ARD_RD drives mem_addr = ard_addr with mem_we = 0.
  - ARD_WAIT captures ard_rdata = mem_rdata[ARD_W-1:0], pulses ard_valid (cycle 3) and returns to IDLE.
- mem_we is 0 in every state except CPU_ACC with a latched store.
- A new request can be granted in the same cycle the previous done/valid pulse is high (IDLE).
- A requester that deasserts its request mid-transaction does not abort it.
- A requester whose request is still high in the IDLE cycle where its done pulse is asserted is treated as a new request.
- Reset mid-operation:
  - The FSM aborts to IDLE and no done/valid pulse is issued.
  - mem_we is 0 from the next cycle.
  - RAM words already written stay written.

Test Plan:
- Scalar store then load:
  - store: cpu_req, we=1, vec=0, addr=0x00010, lane0=0xDEADBEEF -> mem_we high cycle 1 only, cpu_done cycle 2;
  - load: same address, we=0 -> cpu_rdata lane0=0xDEADBEEF, cpu_done cycle 3.
- Vector store then load:
  - store: addr=0x00100, lane i = 0x1000+i -> mem_addr 0x100..0x10F in cycles 1–16, done cycle 17;
  - load -> all 16 lanes match, done cycle 18.
- Address wrap: vector load at addr=0xFFFF8 -> mem_addr 0xFFFF8..0xFFFFF, then 0x00000..0x00007.
- Simultaneous requests:
  - cpu_req and ard_req both high from reset -> CPU served first, then Arduino;
  - both held continuously -> grants alternate CPU, ARD, CPU.
- Arduino read: RAM[0x00005]=0x0000ABCD, ard_req with ard_addr=5 -> ard_valid cycle 3, ard_rdata=0xABCD, mem_we stays 0.
- Reset mid-operation: rst asserted during lane 7 of a vector store -> FSM returns to IDLE, no cpu_done, mem_we=0 next cycle, lanes 0–6 (and lane 7 if written that cycle) retained, busy=0.
